// File: rtl/ad_capture_module.sv
// AD9280-class capture front end: divided sample clock, optional rising-edge
// level trigger, and a DEPTH x 8 read-first capture buffer.
module ad_capture_module #(
   parameter  int CLK_DIV = 4,
   parameter  int DEPTH   = 256,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   output logic          ad_clk,
   input  logic [7:0]    ad_data,
   input  logic          arm,
   input  logic          trig_en,
   input  logic [7:0]    trig_level,
   output logic          busy,
   output logic          done,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] HALF    = DW'(CLK_DIV / 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [DW-1:0]   r_div;
   logic [DW-1:0]   w_div_nxt;
   logic            r_ad_clk;
   logic            w_stb;
   logic [7:0]      r_sample;
   logic            r_prev_vld;
   logic [7:0]      r_lvl;
   logic [AW-1:0]   r_waddr;
   logic            w_we;
   logic            w_arm_ok;
   logic            w_trig;
   logic            w_last;
   logic [7:0]      r_mem [DEPTH];

   assign w_div_nxt = (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
   assign w_stb     = (r_div == '0);
   assign w_arm_ok  = arm && (r_state == S_IDLE || r_state == S_DONE);
   assign w_last    = (r_waddr == AW'(DEPTH - 1));

   // r_sample holds the previous strobe's sample; r_prev_vld masks the
   // stale pre-arm value so the first armed strobe can never trigger.
   assign w_trig = w_stb && r_prev_vld &&
                   (r_sample < r_lvl) && (ad_data >= r_lvl);

   assign ad_clk = r_ad_clk;
   assign busy   = (r_state == S_ARMED) || (r_state == S_CAPTURE);
   assign done   = (r_state == S_DONE);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (arm) begin
               w_state_nxt = trig_en ? S_ARMED : S_CAPTURE;
            end
         end
         S_ARMED: begin
            if (w_trig) begin
               w_we        = 1'b1;
               w_state_nxt = w_last ? S_DONE : S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (w_stb) begin
               w_we = 1'b1;
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_div      <= '0;
         r_ad_clk   <= 1'b0;
         r_sample   <= '0;
         r_prev_vld <= 1'b0;
         r_lvl      <= '0;
         r_waddr    <= '0;
      end else begin
         r_div    <= w_div_nxt;
         r_ad_clk <= (w_div_nxt >= HALF);
         if (w_stb) begin
            r_sample <= ad_data;
         end
         if (w_arm_ok) begin
            r_waddr    <= '0;
            r_lvl      <= trig_level;
            r_prev_vld <= 1'b0;
         end else begin
            if (w_we && !w_last) begin
               r_waddr <= r_waddr + 1'b1;
            end
            if (w_stb && r_state == S_ARMED) begin
               r_prev_vld <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (w_we) begin
         r_mem[r_waddr] <= ad_data;
      end
   end

   // Registered read of the pre-write content gives read-first behaviour.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= r_mem[rd_addr];
      end
   end

endmodule

// File: tb/tb_ad_capture_module.sv
// Directed bench for ad_capture_module: clocking, immediate and triggered
// capture, arm rules and mid-capture reset.
module tb_ad_capture_module;

   localparam int CLK_DIV = 4;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       ad_clk;
   logic [7:0] ad_data;
   logic       arm;
   logic       trig_en;
   logic [7:0] trig_level;
   logic       busy;
   logic       done;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;

   int         checks   = 0;
   int         failures = 0;
   int         tb_div   = 0;
   int         nstb     = 0;
   logic [7:0] inc      = 8'd0;
   logic [7:0] base;

   ad_capture_module #(.CLK_DIV(CLK_DIV), .DEPTH(256)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .ad_clk     (ad_clk),
      .ad_data    (ad_data),
      .arm        (arm),
      .trig_en    (trig_en),
      .trig_level (trig_level),
      .busy       (busy),
      .done       (done),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; ad_data advances just after every strobe edge.
   task automatic step();
      logic was;
      @(posedge sys_clk);
      was    = sys_rst_n && (tb_div == 0);
      tb_div = sys_rst_n ? (tb_div + 1) % CLK_DIV : 0;
      #1;
      if (was) begin
         nstb++;
         ad_data = 8'(ad_data + inc);
      end
   endtask

   task automatic wait_div(input int p);
      for (int i = 0; i < CLK_DIV && tb_div != p; i++) step();
   endtask

   task automatic wait_strobes(input int n);
      int target;
      target = nstb + n;
      while (nstb < target) step();
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      for (int i = 0; i < max_cyc && done !== 1'b1; i++) step();
      chk(tag, done, 1);
   endtask

   task automatic arm_at(input logic te, input logic [7:0] lvl);
      wait_div(2);
      trig_en    = te;
      trig_level = lvl;
      arm        = 1'b1;
      base       = ad_data;
      step();
      arm        = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] e,
                     input string tag);
      rd_addr = a;
      step();
      chk(tag, rd_data, e);
   endtask

   initial begin
      logic [7:0] clk_exp;
      logic [7:0] base2;
      clk_exp    = 8'b0110_0110;
      sys_rst_n  = 1'b0;
      arm        = 1'b0;
      trig_en    = 1'b0;
      trig_level = 8'h00;
      ad_data    = 8'h00;
      rd_addr    = 8'h00;

      // reset and clock
      repeat (3) @(negedge sys_clk);
      chk("rst_adclk", ad_clk, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rddata", rd_data, 0);
      sys_rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk($sformatf("adclk_%0d", k), ad_clk, clk_exp[7-k]);
      end
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);

      // immediate capture, ramp +1
      inc = 8'd1;
      arm_at(1'b0, 8'h00);
      chk("imm_busy", busy, 1);
      chk("imm_done0", done, 0);
      wait_strobes(255);
      chk("imm_busy255", busy, 1);
      chk("imm_done255", done, 0);
      wait_strobes(1);
      step();
      chk("imm_done", done, 1);
      chk("imm_busy_end", busy, 0);
      repeat (8) step();
      chk("imm_done_hold", done, 1);
      rd(8'd0,   base,              "imm_m0");
      rd(8'd1,   8'(base + 1),      "imm_m1");
      rd(8'd100, 8'(base + 100),    "imm_m100");
      rd(8'd255, 8'(base + 255),    "imm_m255");

      // rising trigger from 0x70, re-armed from DONE
      wait_div(1);
      ad_data = 8'h70;
      inc     = 8'd1;
      arm_at(1'b1, 8'h80);
      trig_level = 8'h00;
      chk("trg_done_drop", done, 0);
      chk("trg_busy", busy, 1);
      wait_done("trg_done", 1400);
      rd(8'd0,   8'h80, "trg_m0");
      rd(8'd1,   8'h81, "trg_m1");
      rd(8'd255, 8'h7F, "trg_m255");

      // falling ramp must not trigger
      wait_div(1);
      ad_data = 8'hFF;
      inc     = 8'hFF;
      arm_at(1'b1, 8'h80);
      wait_strobes(250);
      chk("fall_busy", busy, 1);
      chk("fall_done", done, 0);
      rd(8'd0,    8'h80, "fall_m0");
      rd(8'h10,   8'h90, "fall_m16");

      // reset out of ARMED, then first armed sample above level
      sys_rst_n = 1'b0;
      tb_div    = 0;
      #1;
      chk("rarm_busy", busy, 0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      inc       = 8'd0;
      ad_data   = 8'h10;
      wait_strobes(2);
      ad_data = 8'h90;
      arm_at(1'b1, 8'h80);
      wait_strobes(2);
      ad_data = 8'h10;
      chk("first_busy", busy, 1);
      chk("first_done", done, 0);
      wait_strobes(1);
      ad_data = 8'h85;
      inc     = 8'd1;
      wait_done("first_done_end", 1400);
      rd(8'd0,   8'h85, "first_m0");
      rd(8'd1,   8'h86, "first_m1");
      rd(8'd255, 8'h84, "first_m255");

      // arm mid-capture ignored
      arm_at(1'b0, 8'h00);
      wait_strobes(50);
      trig_en = 1'b1;
      arm     = 1'b1;
      step();
      arm     = 1'b0;
      chk("midarm_busy", busy, 1);
      wait_strobes(206);
      step();
      chk("midarm_done", done, 1);
      rd(8'd0,   base,           "midarm_m0");
      rd(8'd200, 8'(base + 200), "midarm_m200");

      // reset mid-capture after 100 samples
      arm_at(1'b0, 8'h00);
      wait_strobes(100);
      sys_rst_n = 1'b0;
      tb_div    = 0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_adclk", ad_clk, 0);
      chk("mrst_rddata", rd_data, 0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      arm_at(1'b0, 8'h00);
      base2 = base;
      chk("mrst_busy2", busy, 1);
      wait_strobes(256);
      step();
      chk("mrst_done2", done, 1);
      rd(8'd0,   base2,            "mrst_m0");
      rd(8'd99,  8'(base2 + 99),   "mrst_m99");
      rd(8'd255, 8'(base2 + 255),  "mrst_m255");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
